sr_bank_sequencer: RTL

- Shared-resource controller for a bank of NBITS master-slave SR flip-flops.
- NREQ requesters each ask to set or clear one bit of the bank.
- The block arbitrates round-robin between them and drives one legal S or R pulse per operation. S=R=1 is never produced on any bit.
- After each operation it checks the bank's Q feedback, grants the winning requester, and flags any mismatch.

---
 rtl/sr_bank_sequencer.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/sr_bank_sequencer.sv
// Round-robin sequencer that drives single legal S/R pulses into a bank of SR flip-flops.
// Optional build macro SR_SKIP_REDUNDANT_EN bypasses the pulse when Q already matches the request.
module sr_bank_sequencer #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned NBITS = 8,
  parameter int unsigned IDXW  = 4,
  parameter int unsigned HOLD  = 2
) (
  input  logic                 C,
  input  logic                 nRST,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ-1:0]      op,
  input  logic [NREQ*IDXW-1:0] idx,
  input  logic [NBITS-1:0]     Q_fb,
  input  logic                 err_clr,
  output logic [NBITS-1:0]     S,
  output logic [NBITS-1:0]     R,
  output logic [NREQ-1:0]      gnt,
  output logic                 busy,
  output logic [2:0]           cur_id,
  output logic                 err
);

  localparam int unsigned CW = (HOLD > 1) ? $clog2(HOLD) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_DRIVE, ST_GUARD, ST_CHECK} state_t;

  state_t          r_state, w_next;
  logic [2:0]      r_ptr, r_id;
  logic            r_op;
  logic [IDXW-1:0] r_idx;
  logic [CW-1:0]   r_cnt;

  logic            w_any;
  logic [2:0]      w_win;
  logic            w_win_op;
  logic [IDXW-1:0] w_win_idx;
  int              w_best, w_dist;
  logic [NBITS-1:0] w_sel;
  logic            w_in_range, w_q_cur, w_err_set;
  logic [NBITS-1:0] w_s, w_r;
  logic [NREQ-1:0] w_gnt;
  logic            w_busy;

  // Round-robin pick: smallest rotational distance after r_ptr wins.
  always_comb begin
    w_any  = 1'b0;
    w_win  = '0;
    w_best = int'(NREQ);
    w_dist = 0;
    for (int i = 0; i < int'(NREQ); i++) begin
      w_dist = (i + 2 * int'(NREQ) - 1 - int'(r_ptr)) % int'(NREQ);
      if (req[i] && (w_dist < w_best)) begin
        w_best = w_dist;
        w_win  = 3'(i);
        w_any  = 1'b1;
      end
    end
  end

  always_comb begin
    w_win_op  = 1'b0;
    w_win_idx = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (w_win == 3'(i)) begin
        w_win_op  = op[i];
        w_win_idx = idx[i*IDXW +: IDXW];
      end
    end
  end

`ifdef SR_SKIP_REDUNDANT_EN
  logic w_win_q;
  always_comb begin
    w_win_q = 1'b0;
    for (int b = 0; b < int'(NBITS); b++) begin
      if (w_win_idx == IDXW'(b)) w_win_q = Q_fb[b];
    end
  end
`endif

  // One-hot decode of the latched index; an out-of-range index selects nothing.
  always_comb begin
    w_sel   = '0;
    w_q_cur = 1'b0;
    for (int b = 0; b < int'(NBITS); b++) begin
      if (r_idx == IDXW'(b)) begin
        w_sel[b] = 1'b1;
        w_q_cur  = Q_fb[b];
      end
    end
    w_in_range = |w_sel;
  end

  always_ff @(posedge C or negedge nRST) begin
    if (!nRST) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_any) begin
`ifdef SR_SKIP_REDUNDANT_EN
          w_next = (w_win_q == w_win_op) ? ST_CHECK : ST_DRIVE;
`else
          w_next = ST_DRIVE;
`endif
        end
      end
      ST_DRIVE: if (r_cnt == '0) w_next = ST_GUARD;
      ST_GUARD: w_next = ST_CHECK;
      ST_CHECK: w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_s       = '0;
    w_r       = '0;
    w_gnt     = '0;
    w_busy    = (r_state != ST_IDLE);
    w_err_set = 1'b0;
    case (r_state)
      ST_DRIVE: begin
        if (r_op) w_s = w_sel;
        else      w_r = w_sel;
      end
      ST_CHECK: begin
        for (int i = 0; i < int'(NREQ); i++) begin
          if (r_id == 3'(i)) w_gnt[i] = 1'b1;
        end
        w_err_set = !w_in_range || (w_q_cur != r_op);
      end
      default: ;
    endcase
  end

  // Operation context and hold counter.
  always_ff @(posedge C or negedge nRST) begin
    if (!nRST) begin
      r_ptr <= 3'(NREQ - 1);
      r_id  <= '0;
      r_op  <= 1'b0;
      r_idx <= '0;
      r_cnt <= '0;
    end else begin
      if ((r_state == ST_IDLE) && w_any) begin
        r_id  <= w_win;
        r_op  <= w_win_op;
        r_idx <= w_win_idx;
        r_cnt <= CW'(HOLD - 1);
      end else if ((r_state == ST_DRIVE) && (r_cnt != '0)) begin
        r_cnt <= r_cnt - CW'(1);
      end
      if (r_state == ST_CHECK) r_ptr <= r_id;
    end
  end

  // Registered outputs; err set takes priority over err_clr.
  always_ff @(posedge C or negedge nRST) begin
    if (!nRST) begin
      S    <= '0;
      R    <= '0;
      gnt  <= '0;
      busy <= 1'b0;
      err  <= 1'b0;
    end else begin
      S    <= w_s;
      R    <= w_r;
      gnt  <= w_gnt;
      busy <= w_busy;
      if (w_err_set)    err <= 1'b1;
      else if (err_clr) err <= 1'b0;
    end
  end

  assign cur_id = r_id;

endmodule
